secuenciador_cuenta: RTL and testbench

Upstream feeder for the 3-bit ones-counter datapath. Buffers incoming 3-bit words in a small FIFO and launches one count per word (drives Valor and start). Waits for the counter's fin, then captures its Cuenta into last-result and running-total registers. Lets a producer stream words without tracking counter busy time.

---
 rtl/secuenciador_defs.sv | 22 ++
 rtl/fifo_val.sv | 69 ++++++
 rtl/secuenciador_cuenta.sv | 158 +++++++++++++++
 tb/tb_secuenciador_cuenta.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_defs.sv
// secuenciador_defs
// Shared definitions for the ones-counter feeder (secuenciador_cuenta) and its
// word FIFO (fifo_val):
//   - sequencer state encoding
//   - widths of the counted word and of the count result
//   - watchdog width and limit, used only when SECUENCIADOR_TIMEOUT_EN is defined
package secuenciador_defs;

  localparam int VAL_W    = 3;   // width of a word presented to the counter
  localparam int CNT_W    = 4;   // width of the counter's Cuenta result
  localparam int WD_W     = 6;   // watchdog counter width
  localparam int WD_LIMIT = 63;  // watchdog value at which a job is abandoned

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LANZA       = 3'd1,
    ESPERA_BAJA = 3'd2,
    ESPERA_FIN  = 3'd3,
    CAPTURA     = 3'd4
  } estado_t;

endpackage

// File: rtl/fifo_val.sv
// fifo_val
// DEPTH x 3-bit FIFO that buffers words waiting to be counted.
// The head word is read combinationally so the sequencer can latch it in the
// same cycle it decides to launch.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   push, din          write din at the tail (ignored when full)
//   pop                drop the head word (ignored when empty)
//   head               word currently at the head
//   full, empty, occ   status flags and occupancy
module fifo_val
  import secuenciador_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [VAL_W-1:0]           din,
  input  logic                       pop,
  output logic [VAL_W-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [VAL_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign occ     = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/secuenciador_cuenta.sv
// secuenciador_cuenta
// Feeder for the 3-bit ones-counter. Buffers incoming words, launches one
// count per word, waits for the counter's fin, and accumulates its results.
// Optional macro SECUENCIADOR_TIMEOUT_EN adds a watchdog and a sticky error
// output. A job that waits too long for fin is dropped.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   dato_in/valid/ready        producer side (ready = FIFO not full)
//   Valor, start               word and one-cycle launch pulse to the counter
//   Cuenta, fin                result and done level from the counter
//   ultima, total, hecho       last result, saturating sum, capture pulse
//   vacio                      nothing queued and sequencer idle
//   error (optional)           watchdog expired at least once since reset
module secuenciador_cuenta
  import secuenciador_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int WT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VAL_W-1:0]  dato_in,
  input  logic              dato_valid,
  output logic              dato_ready,
  output logic [VAL_W-1:0]  Valor,
  output logic              start,
  input  logic [CNT_W-1:0]  Cuenta,
  input  logic              fin,
  output logic [CNT_W-1:0]  ultima,
  output logic [WT-1:0]     total,
  output logic              hecho,
  output logic              vacio
`ifdef SECUENCIADOR_TIMEOUT_EN
  ,
  output logic              error
`endif
);

  estado_t                estado_q, estado_d;
  logic [VAL_W-1:0]       valor_q, valor_d;
  logic [CNT_W-1:0]       ultima_q, ultima_d;
  logic [WT-1:0]          total_q, total_d;
  logic [WT:0]            suma;

  logic                   fifo_push, fifo_pop;
  logic [VAL_W-1:0]       fifo_head;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_occ;

`ifdef SECUENCIADOR_TIMEOUT_EN
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   error_q, error_d;
  assign error = error_q;
`endif

  fifo_val #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (dato_in),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .occ   (fifo_occ)
  );

  assign dato_ready = ~fifo_full;
  assign fifo_push  = dato_valid & dato_ready;
  assign Valor      = valor_q;
  assign ultima     = ultima_q;
  assign total      = total_q;
  assign vacio      = (fifo_occ == '0) && (estado_q == IDLE);

  // One extra bit catches the carry so the total can clamp instead of wrapping.
  assign suma = {1'b0, total_q} + {{(WT + 1 - CNT_W){1'b0}}, Cuenta};

  always_comb begin
    estado_d = estado_q;
    valor_d  = valor_q;
    ultima_d = ultima_q;
    total_d  = total_q;
    fifo_pop = 1'b0;
    start    = 1'b0;
    hecho    = 1'b0;
`ifdef SECUENCIADOR_TIMEOUT_EN
    wd_d     = wd_q;
    error_d  = error_q;
`endif

    case (estado_q)
      IDLE: begin
        if (!fifo_empty) begin
          valor_d  = fifo_head;
          estado_d = LANZA;
        end
      end
      LANZA: begin
        start    = 1'b1;
        estado_d = ESPERA_BAJA;
`ifdef SECUENCIADOR_TIMEOUT_EN
        wd_d     = '0;
`endif
      end
      // fin may still be high from the previous job; see it drop first.
      ESPERA_BAJA: begin
        if (!fin) estado_d = ESPERA_FIN;
      end
      ESPERA_FIN: begin
        if (fin) estado_d = CAPTURA;
      end
      CAPTURA: begin
        ultima_d = Cuenta;
        total_d  = suma[WT] ? {WT{1'b1}} : suma[WT-1:0];
        hecho    = 1'b1;
        fifo_pop = 1'b1;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase

`ifdef SECUENCIADOR_TIMEOUT_EN
    // Watchdog overrides the wait states: the word is discarded with no capture.
    if (estado_q == ESPERA_BAJA || estado_q == ESPERA_FIN) begin
      if (wd_q == WD_W'(WD_LIMIT)) begin
        error_d  = 1'b1;
        fifo_pop = 1'b1;
        estado_d = IDLE;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      valor_q  <= '0;
      ultima_q <= '0;
      total_q  <= '0;
`ifdef SECUENCIADOR_TIMEOUT_EN
      wd_q     <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      valor_q  <= valor_d;
      ultima_q <= ultima_d;
      total_q  <= total_d;
`ifdef SECUENCIADOR_TIMEOUT_EN
      wd_q     <= wd_d;
      error_q  <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_secuenciador_cuenta.sv
// tb_secuenciador_cuenta
// Directed bench for secuenciador_cuenta (built with WT=4 so saturation is
// reachable). A behavioural counter answers each start: fin falls the cycle
// after start, rises 4 cycles later, and Cuenta = popcount(Valor).
// Define SECUENCIADOR_TIMEOUT_EN to also exercise the watchdog.
module tb_secuenciador_cuenta;

  localparam int WT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    dato_in;
  logic          dato_valid;
  logic          dato_ready;
  logic [2:0]    Valor;
  logic          start;
  logic [3:0]    Cuenta;
  logic          fin;
  logic [3:0]    ultima;
  logic [WT-1:0] total;
  logic          hecho;
  logic          vacio;
`ifdef SECUENCIADOR_TIMEOUT_EN
  logic          error;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  secuenciador_cuenta #(.DEPTH(4), .WT(WT)) dut (
    .clk        (clk),
    .reset      (reset),
    .dato_in    (dato_in),
    .dato_valid (dato_valid),
    .dato_ready (dato_ready),
    .Valor      (Valor),
    .start      (start),
    .Cuenta     (Cuenta),
    .fin        (fin),
    .ultima     (ultima),
    .total      (total),
    .hecho      (hecho),
    .vacio      (vacio)
`ifdef SECUENCIADOR_TIMEOUT_EN
    ,
    .error      (error)
`endif
  );

  // ---------------- behavioural counter ----------------
  logic       fin_m;
  int         cnt_m;
  logic [3:0] cuenta_m;
  logic       fin_hold  = 1'b0;  // force fin high (stale fin)
  logic       fin_never = 1'b0;  // force fin low (dead counter)

  function automatic logic [3:0] popcount(input logic [2:0] v);
    return {3'b0, v[0]} + {3'b0, v[1]} + {3'b0, v[2]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fin_m    <= 1'b1;
      cnt_m    <= 0;
      cuenta_m <= '0;
    end else if (start === 1'b1) begin
      fin_m    <= 1'b0;
      cnt_m    <= 4;
      cuenta_m <= popcount(Valor);
    end else if (!fin_hold && cnt_m > 0) begin
      cnt_m <= cnt_m - 1;
      if (cnt_m == 1) fin_m <= 1'b1;
    end
  end

  assign fin    = fin_hold ? 1'b1 : (fin_never ? 1'b0 : fin_m);
  assign Cuenta = cuenta_m;

  // ---------------- monitor ----------------
  // One start_log entry per cycle with start high; one ultima/total entry per
  // capture, sampled the cycle after hecho.
  logic [2:0]    start_log[$];
  logic [3:0]    ultima_log[$];
  logic [WT-1:0] total_log[$];
  logic          hecho_prev = 1'b0;

  always @(negedge clk) begin
    if (start === 1'b1) start_log.push_back(Valor);
    if (hecho_prev) begin
      ultima_log.push_back(ultima);
      total_log.push_back(total);
    end
    hecho_prev <= (hecho === 1'b1);
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    start_log.delete();
    ultima_log.delete();
    total_log.delete();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    dato_valid = 1'b0;
    dato_in    = '0;
    fin_hold   = 1'b0;
    fin_never  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic push(input logic [2:0] v);
    int n;
    n          = 0;
    dato_in    = v;
    dato_valid = 1'b1;
    while (dato_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("push_ready_timeout", n, 0);
    tick();
    dato_valid = 1'b0;
  endtask

  task automatic wait_captures(input string tag, input int n, input int bound);
    int i;
    i = 0;
    while (ultima_log.size() < n && i < bound) begin
      tick();
      i++;
    end
    check(tag, ultima_log.size(), n);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base_starts;
    int base_caps;
    int i;
    logic [3:0] sat_exp [6];
    sat_exp = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15};

    // Reset values, checked while reset is still asserted.
    reset      = 1'b1;
    dato_valid = 1'b0;
    dato_in    = '0;
    tick();
    check("rst_valor", Valor, 0);
    check("rst_start", start, 0);
    check("rst_ultima", ultima, 0);
    check("rst_total", total, 0);
    check("rst_hecho", hecho, 0);
    check("rst_vacio", vacio, 1);
    check("rst_ready", dato_ready, 1);
`ifdef SECUENCIADOR_TIMEOUT_EN
    check("rst_error", error, 0);
`endif
    do_reset();

    // Single word 5 -> one 1-cycle start, ultima=2, total=2.
    push(3'd5);
    check("single_not_vacio", vacio, 0);
    wait_captures("single_capture", 1, 60);
    check("single_start_cycles", start_log.size(), 1);
    check("single_valor", start_log[0], 5);
    check("single_ultima", ultima_log[0], 2);
    check("single_total", total_log[0], 2);
    tick();
    check("single_vacio", vacio, 1);
    check("single_hecho_low", hecho, 0);

    // Burst 7,0,3,6: FIFO fills, launches in order, total=7.
    do_reset();
    push(3'd7);
    push(3'd0);
    push(3'd3);
    push(3'd6);
    check("burst_ready_low", dato_ready, 0);
    wait_captures("burst_captures", 4, 200);
    check("burst_starts", start_log.size(), 4);
    check("burst_start0", start_log[0], 7);
    check("burst_start1", start_log[1], 0);
    check("burst_start2", start_log[2], 3);
    check("burst_start3", start_log[3], 6);
    check("burst_ultima0", ultima_log[0], 3);
    check("burst_ultima1", ultima_log[1], 0);
    check("burst_ultima2", ultima_log[2], 2);
    check("burst_ultima3", ultima_log[3], 2);
    check("burst_total", total_log[3], 7);

    // Stale fin held high: no capture until fin drops and rises again.
    do_reset();
    fin_hold = 1'b1;
    push(3'd6);
    i = 0;
    while (start_log.size() == 0 && i < 20) begin
      tick();
      i++;
    end
    check("stale_started", start_log.size(), 1);
    repeat (10) tick();
    check("stale_no_capture", ultima_log.size(), 0);
    fin_hold = 1'b0;
    wait_captures("stale_capture", 1, 60);
    check("stale_ultima", ultima_log[0], 2);
    check("stale_total", total_log[0], 2);

    // Saturation with WT=4: six words of 7.
    do_reset();
    for (int k = 0; k < 6; k++) push(3'd7);
    wait_captures("sat_captures", 6, 300);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("sat_total%0d", k), total_log[k], sat_exp[k]);
    end

    // Async reset in ESPERA_FIN with two words queued (total is 15 here).
    base_starts = start_log.size();
    push(3'd7);   // launched next cycle
    push(3'd7);   // its edge moves FSM to LANZA
    push(3'd7);   // its edge moves FSM to ESPERA_BAJA, fin falls
    tick();       // ESPERA_FIN
    check("ar_launched", start_log.size(), base_starts + 1);
    check("ar_total_before", total, 15);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valor", Valor, 0);
    check("ar_start", start, 0);
    check("ar_ultima", ultima, 0);
    check("ar_total", total, 0);
    check("ar_hecho", hecho, 0);
    check("ar_vacio", vacio, 1);
    check("ar_ready", dato_ready, 1);
    tick();
    reset       = 1'b0;
    base_starts = start_log.size();
    base_caps   = ultima_log.size();
    repeat (15) tick();
    check("ar_no_start", start_log.size(), base_starts);
    check("ar_no_capture", ultima_log.size(), base_caps);
    check("ar_total_after", total, 0);
    check("ar_vacio_after", vacio, 1);

`ifdef SECUENCIADOR_TIMEOUT_EN
    // Dead counter: watchdog drops word 3, then word 5 runs normally.
    do_reset();
    fin_never = 1'b1;
    push(3'd3);
    push(3'd5);
    i = 0;
    while (error !== 1'b1 && i < 150) begin
      tick();
      i++;
    end
    check("to_error", error, 1);
    check("to_no_capture", ultima_log.size(), 0);
    check("to_total", total, 0);
    check("to_first_start", start_log[0], 3);
    fin_never = 1'b0;
    wait_captures("to_next_capture", 1, 60);
    check("to_next_start", start_log[1], 5);
    check("to_next_ultima", ultima_log[0], 2);
    check("to_next_total", total_log[0], 2);
    check("to_error_sticky", error, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
